// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video types, screen defaults and FSM state encoding
package video_pkg;

  localparam int DEFAULT_SCREEN_W = 1280;
  localparam int DEFAULT_SCREEN_H = 720;
  localparam int RAW_W            = 12;

  typedef logic [10:0] hcount_t;
  typedef logic [9:0]  vcount_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    HOLD     = 2'd2,
    RECENTER = 2'd3
  } pos_state_t;

endpackage

// File: rtl/sprite_position_ctrl_if.sv
// rtl/sprite_position_ctrl_if.sv - timing, centroid and sprite-position signal bundle
interface sprite_position_ctrl_if;
  import video_pkg::*;

  hcount_t    hcount_in;
  vcount_t    vcount_in;
  hcount_t    centroid_x_in;
  vcount_t    centroid_y_in;
  logic       centroid_valid_in;
  logic       pop_gesture_in;
  hcount_t    x_out;
  vcount_t    y_out;
  logic       pop_out;
  logic       frame_update_out;
  logic [1:0] state_out;

  modport master (
    output hcount_in, vcount_in, centroid_x_in, centroid_y_in,
           centroid_valid_in, pop_gesture_in,
    input  x_out, y_out, pop_out, frame_update_out, state_out
  );

  modport slave (
    input  hcount_in, vcount_in, centroid_x_in, centroid_y_in,
           centroid_valid_in, pop_gesture_in,
    output x_out, y_out, pop_out, frame_update_out, state_out
  );

endinterface

// File: rtl/sprite_position_ctrl_axis_smoother.sv
// rtl/sprite_position_ctrl_axis_smoother.sv - per-axis target clamp and one smoothing step
module axis_smoother
  import video_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int MAX_POS = 1024,
  parameter int SHIFT   = 2
) (
  input  logic signed [RAW_W-1:0] i_raw,
  output logic [WIDTH-1:0]        o_clamped,
  input  logic [WIDTH-1:0]        i_target,
  input  logic [WIDTH-1:0]        i_pos,
  input  logic                    i_step_en,
  output logic [WIDTH-1:0]        o_next_pos
);

  localparam logic signed [RAW_W-1:0] RAW_MAX = RAW_W'(MAX_POS);
  localparam logic signed [WIDTH:0]   SMALL   = (WIDTH+1)'(1 << SHIFT);
  localparam logic signed [WIDTH:0]   ONE     = (WIDTH+1)'(1);

  logic signed [WIDTH:0] w_diff;
  logic signed [WIDTH:0] w_mag;
  logic signed [WIDTH:0] w_step;
  logic [WIDTH-1:0]      w_sum;

  always_comb begin
    if (i_raw[RAW_W-1])
      o_clamped = '0;
    else if (i_raw > RAW_MAX)
      o_clamped = WIDTH'(MAX_POS);
    else
      o_clamped = i_raw[WIDTH-1:0];
  end

  assign w_diff = $signed({1'b0, i_target}) - $signed({1'b0, i_pos});
  assign w_mag  = w_diff[WIDTH] ? -w_diff : w_diff;

  // Differences below 2^SHIFT would shift to zero, so nudge by one to converge
  always_comb begin
    w_step = '0;
    if (w_diff == '0)
      w_step = '0;
    else if (w_mag < SMALL)
      w_step = w_diff[WIDTH] ? '1 : ONE;
    else
      w_step = w_diff >>> SHIFT;
  end

  assign w_sum      = WIDTH'($signed({1'b0, i_pos}) + w_step);
  assign o_next_pos = i_step_en ? w_sum : i_pos;

endmodule

// File: rtl/sprite_position_ctrl.sv
// rtl/sprite_position_ctrl.sv - frame-synchronous sprite position, recentre and pop control
module sprite_position_ctrl
  import video_pkg::*;
#(
  parameter int SCREEN_W     = DEFAULT_SCREEN_W,
  parameter int SCREEN_H     = DEFAULT_SCREEN_H,
  parameter int SPRITE_W     = 256,
  parameter int SPRITE_H     = 256,
  parameter int SMOOTH_SHIFT = 2,
  parameter int LOST_FRAMES  = 30,
  parameter int POP_HOLD     = 8
) (
  input logic             pixel_clk_in,
  input logic             rst_in,
  sprite_position_ctrl_if.slave bus
);

  localparam int      X_MAX    = SCREEN_W - SPRITE_W;
  localparam int      Y_MAX    = SCREEN_H - SPRITE_H;
  localparam hcount_t X_CENTRE = hcount_t'(X_MAX / 2);
  localparam vcount_t Y_CENTRE = vcount_t'(Y_MAX / 2);
  localparam int      LOST_W   = $clog2(LOST_FRAMES + 1);
  localparam int      POP_W    = $clog2(POP_HOLD + 1);

  pos_state_t        r_state;
  hcount_t           r_x, r_tgt_x;
  vcount_t           r_y, r_tgt_y;
  logic              r_seen, r_pop_seen, r_pop, r_frame_update;
  logic [LOST_W-1:0] r_lost_cnt;
  logic [POP_W-1:0]  r_pop_cnt;

  logic                    w_frame_tick, w_step_en;
  logic signed [RAW_W-1:0] w_raw_x, w_raw_y;
  hcount_t                 w_clamp_x, w_aim_x, w_next_x;
  vcount_t                 w_clamp_y, w_aim_y, w_next_y;

  assign w_frame_tick = (bus.hcount_in == '0) && (bus.vcount_in == vcount_t'(SCREEN_H));
  assign w_raw_x = $signed(RAW_W'(bus.centroid_x_in)) - $signed(RAW_W'(SPRITE_W / 2));
  assign w_raw_y = $signed(RAW_W'(bus.centroid_y_in)) - $signed(RAW_W'(SPRITE_H / 2));

  // A fresh sample during RECENTER aims at the hand; otherwise RECENTER aims at centre
  assign w_aim_x   = (r_state == RECENTER && !r_seen) ? X_CENTRE : r_tgt_x;
  assign w_aim_y   = (r_state == RECENTER && !r_seen) ? Y_CENTRE : r_tgt_y;
  assign w_step_en = w_frame_tick && (r_seen || r_state == RECENTER);

  axis_smoother #(.WIDTH(11), .MAX_POS(X_MAX), .SHIFT(SMOOTH_SHIFT)) u_smooth_x (
    .i_raw(w_raw_x), .o_clamped(w_clamp_x), .i_target(w_aim_x),
    .i_pos(r_x), .i_step_en(w_step_en), .o_next_pos(w_next_x)
  );

  axis_smoother #(.WIDTH(10), .MAX_POS(Y_MAX), .SHIFT(SMOOTH_SHIFT)) u_smooth_y (
    .i_raw(w_raw_y), .o_clamped(w_clamp_y), .i_target(w_aim_y),
    .i_pos(r_y), .i_step_en(w_step_en), .o_next_pos(w_next_y)
  );

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state        <= IDLE;
      r_x            <= X_CENTRE;
      r_y            <= Y_CENTRE;
      r_tgt_x        <= X_CENTRE;
      r_tgt_y        <= Y_CENTRE;
      r_seen         <= 1'b0;
      r_pop_seen     <= 1'b0;
      r_pop          <= 1'b0;
      r_frame_update <= 1'b0;
      r_lost_cnt     <= '0;
      r_pop_cnt      <= '0;
    end else begin
      r_frame_update <= w_frame_tick;
      if (bus.centroid_valid_in) begin
        r_tgt_x    <= w_clamp_x;
        r_tgt_y    <= w_clamp_y;
        r_pop_seen <= bus.pop_gesture_in;
      end
      if (w_frame_tick) begin
        // The tick consumes the previous frame's seen; a coincident sample arms the next frame
        r_seen <= bus.centroid_valid_in;
        r_x    <= w_next_x;
        r_y    <= w_next_y;
        if (r_seen && r_pop_seen) begin
          if (r_pop_cnt != POP_W'(POP_HOLD))
            r_pop_cnt <= r_pop_cnt + POP_W'(1);
          r_pop <= (r_pop_cnt >= POP_W'(POP_HOLD - 1));
        end else begin
          r_pop_cnt <= '0;
          r_pop     <= 1'b0;
        end
        case (r_state)
          IDLE: begin
            if (r_seen) begin
              r_state    <= TRACK;
              r_lost_cnt <= '0;
            end
          end
          TRACK: begin
            if (r_seen) begin
              r_lost_cnt <= '0;
            end else begin
              r_state    <= HOLD;
              r_lost_cnt <= LOST_W'(1);
            end
          end
          HOLD: begin
            if (r_seen) begin
              r_state    <= TRACK;
              r_lost_cnt <= '0;
            end else begin
              r_lost_cnt <= r_lost_cnt + LOST_W'(1);
              if (r_lost_cnt == LOST_W'(LOST_FRAMES - 1)) begin
                r_state   <= RECENTER;
                r_pop     <= 1'b0;
                r_pop_cnt <= '0;
              end
            end
          end
          RECENTER: begin
            r_lost_cnt <= '0;
            if (r_seen)
              r_state <= TRACK;
            else if (w_next_x == X_CENTRE && w_next_y == Y_CENTRE)
              r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (bus.centroid_valid_in) begin
        r_seen <= 1'b1;
      end
    end
  end

  assign bus.x_out            = r_x;
  assign bus.y_out            = r_y;
  assign bus.pop_out          = r_pop;
  assign bus.frame_update_out = r_frame_update;
  assign bus.state_out        = r_state;

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// tb/tb_sprite_position_ctrl.sv - directed scoreboard bench for sprite_position_ctrl
module tb_sprite_position_ctrl;
  import video_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_position_ctrl_if bus ();

  sprite_position_ctrl dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .bus         (bus)
  );

  typedef struct {
    int x;
    int y;
    int pop;
    int st;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  int m_x, m_y, m_tx, m_ty, m_seen, m_ps, m_st, m_lost, m_pc, m_pop;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int mstep(input int pos, input int tgt);
    int d;
    d = tgt - pos;
    if (d == 0) return pos;
    if (d > -4 && d < 4) return pos + ((d > 0) ? 1 : -1);
    if (d >= 0) return pos + d / 4;
    return pos - (-d + 3) / 4;
  endfunction

  task automatic m_reset();
    m_x = 512; m_y = 232; m_tx = 512; m_ty = 232;
    m_seen = 0; m_ps = 0; m_st = 0; m_lost = 0; m_pc = 0; m_pop = 0;
  endtask

  task automatic m_capture(input int cx, input int cy, input bit pg);
    m_tx = clampi(cx - 128, 0, 1024);
    m_ty = clampi(cy - 128, 0, 464);
    m_seen = 1;
    m_ps = pg;
  endtask

  task automatic m_tick();
    if (m_seen != 0 && m_ps != 0) begin
      m_pc = (m_pc < 8) ? m_pc + 1 : 8;
      m_pop = (m_pc == 8) ? 1 : 0;
    end else begin
      m_pc = 0;
      m_pop = 0;
    end
    if (m_seen != 0) begin
      m_x = mstep(m_x, m_tx);
      m_y = mstep(m_y, m_ty);
      m_st = 1;
      m_lost = 0;
    end else if (m_st == 1) begin
      m_st = 2;
      m_lost = 1;
    end else if (m_st == 2) begin
      m_lost++;
      if (m_lost == 30) begin
        m_st = 3;
        m_pc = 0;
        m_pop = 0;
      end
    end else if (m_st == 3) begin
      m_x = mstep(m_x, 512);
      m_y = mstep(m_y, 232);
      if (m_x == 512 && m_y == 232) m_st = 0;
    end
    m_seen = 0;
  endtask

  task automatic drive(input int h, input int v, input bit val, input int cx, input int cy, input bit pg);
    bus.hcount_in         = hcount_t'(h);
    bus.vcount_in         = vcount_t'(v);
    bus.centroid_valid_in = val;
    bus.centroid_x_in     = hcount_t'(cx);
    bus.centroid_y_in     = vcount_t'(cy);
    bus.pop_gesture_in    = pg;
  endtask

  // One short frame: a near-miss line, the tick line start, then a near-miss column
  task automatic frame(input bit v, input int cx, input int cy, input bit pg, input bit at_tick);
    exp_t e;
    @(negedge clk);
    drive(0, 719, v && !at_tick, cx, cy, pg);
    if (v && !at_tick) m_capture(cx, cy, pg);
    @(negedge clk);
    drive(0, 720, v && at_tick, cx, cy, pg);
    m_tick();
    if (v && at_tick) m_capture(cx, cy, pg);
    e = '{m_x, m_y, m_pop, m_st};
    sb.push_back(e);
    @(negedge clk);
    drive(5, 720, 1'b0, 0, 0, 1'b0);
    chk("frame_update_pulse", bus.frame_update_out, 1);
    if (bus.frame_update_out === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("x_out", bus.x_out, e.x);
      chk("y_out", bus.y_out, e.y);
      chk("pop_out", bus.pop_out, e.pop);
      chk("state", bus.state_out, e.st);
    end else begin
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk("frame_update_low", bus.frame_update_out, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_x", bus.x_out, 512);
    chk("rst_y", bus.y_out, 232);
    chk("rst_pop", bus.pop_out, 0);
    chk("rst_fu", bus.frame_update_out, 0);
    chk("rst_state", bus.state_out, 0);
  endtask

  initial begin
    m_reset();
    drive(5, 100, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    repeat (2) frame(1'b0, 0, 0, 1'b0, 1'b0);

    frame(1'b1, 1000, 400, 1'b0, 1'b0);
    chk("first_step_x", bus.x_out, 602);
    chk("first_step_y", bus.y_out, 242);
    repeat (30) frame(1'b1, 1000, 400, 1'b0, 1'b0);
    chk("conv_x", bus.x_out, 872);
    chk("conv_y", bus.y_out, 272);

    for (int i = 0; i < 40; i++) begin
      frame(1'b1, 1270, 700, 1'b0, 1'b0);
      chk("x_le_max", (bus.x_out <= 1024) ? 1 : 0, 1);
      chk("y_le_max", (bus.y_out <= 464) ? 1 : 0, 1);
    end
    chk("clamp_hi_x", bus.x_out, 1024);
    chk("clamp_hi_y", bus.y_out, 464);
    repeat (40) frame(1'b1, 10, 5, 1'b0, 1'b0);
    chk("clamp_lo_x", bus.x_out, 0);
    chk("clamp_lo_y", bus.y_out, 0);

    repeat (30) frame(1'b1, 1000, 400, 1'b0, 1'b0);
    frame(1'b1, 600, 300, 1'b0, 1'b1);
    chk("at_tick_old_x", bus.x_out, 872);
    chk("at_tick_old_y", bus.y_out, 272);
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    chk("at_tick_new_x", bus.x_out, 772);
    chk("at_tick_new_y", bus.y_out, 247);

    repeat (30) frame(1'b1, 1000, 400, 1'b0, 1'b0);
    repeat (29) frame(1'b0, 0, 0, 1'b0, 1'b0);
    chk("hold_state", bus.state_out, 2);
    chk("hold_x", bus.x_out, 872);
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    chk("recenter_state", bus.state_out, 3);
    chk("recenter_frozen_y", bus.y_out, 272);
    repeat (3) frame(1'b0, 0, 0, 1'b0, 1'b0);
    frame(1'b1, 1000, 400, 1'b0, 1'b0);
    chk("recenter_to_track", bus.state_out, 1);
    for (int i = 0; i < 100 && bus.state_out != 2'd0; i++)
      frame(1'b0, 0, 0, 1'b0, 1'b0);
    chk("idle_state", bus.state_out, 0);
    chk("idle_x", bus.x_out, 512);
    chk("idle_y", bus.y_out, 232);

    repeat (7) frame(1'b1, 1000, 400, 1'b1, 1'b0);
    chk("pop_7th", bus.pop_out, 0);
    frame(1'b1, 1000, 400, 1'b1, 1'b0);
    chk("pop_8th", bus.pop_out, 1);
    frame(1'b1, 1000, 400, 1'b1, 1'b0);
    chk("pop_9th", bus.pop_out, 1);
    frame(1'b1, 1000, 400, 1'b0, 1'b0);
    chk("pop_drop", bus.pop_out, 0);

    @(negedge clk);
    drive(100, 100, 1'b1, 300, 300, 1'b1);
    @(negedge clk);
    drive(200, 100, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    m_reset();
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    chk("post_rst_x", bus.x_out, 512);
    chk("post_rst_state", bus.state_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
